// File: rtl/rx_frame_controller_if.sv
// rx_frame_controller_if: UART byte input and decoded audio sample outputs of the frame controller.
interface rx_frame_controller_if;
  logic [7:0]  RX_Data;
  logic        RX_Done;
  logic [15:0] Left_Sample;
  logic [15:0] Right_Sample;
  logic        Sample_Valid;
  logic        Checksum_Error;
  logic        Timeout_Error;
  logic [7:0]  Frame_Count;
  modport master (
    output RX_Data, RX_Done,
    input  Left_Sample, Right_Sample, Sample_Valid, Checksum_Error, Timeout_Error, Frame_Count
  );
  modport slave (
    input  RX_Data, RX_Done,
    output Left_Sample, Right_Sample, Sample_Valid, Checksum_Error, Timeout_Error, Frame_Count
  );
endinterface

// File: rtl/rx_frame_controller.sv
// rx_frame_controller: decodes SYNC,L,L,R,R,CHK byte frames into stereo samples with checksum and timeout.
module rx_frame_controller #(
  parameter logic [7:0] SYNC_BYTE      = 8'hA5,
  parameter int         TIMEOUT_CYCLES = 4096
) (
  input  logic CLOCK_50,
  input  logic Reset_n,
  rx_frame_controller_if.slave bus
);
  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] T_MAX = CW'(TIMEOUT_CYCLES - 1);
  typedef enum logic [2:0] {HUNT, L_MSB, L_LSB, R_MSB, R_LSB, CHECK} state_t;
  state_t        state;
  logic          rx_done_q;
  logic [15:0]   left_sh, right_sh;
  logic [7:0]    run_xor;
  logic [CW-1:0] tcnt;
  logic          strobe, expire;
  always_comb begin
    strobe = bus.RX_Done & ~rx_done_q;
    expire = (state != HUNT) && !strobe && (tcnt == T_MAX);
  end
  // a strobe always takes priority over expiry, keeping the three pulses mutually exclusive
  always_ff @(posedge CLOCK_50 or negedge Reset_n) begin
    if (!Reset_n) begin
      state              <= HUNT;
      rx_done_q          <= 1'b1;
      left_sh            <= '0;
      right_sh           <= '0;
      run_xor            <= '0;
      tcnt               <= '0;
      bus.Left_Sample    <= '0;
      bus.Right_Sample   <= '0;
      bus.Sample_Valid   <= 1'b0;
      bus.Checksum_Error <= 1'b0;
      bus.Timeout_Error  <= 1'b0;
      bus.Frame_Count    <= '0;
    end else begin
      rx_done_q          <= bus.RX_Done;
      bus.Sample_Valid   <= 1'b0;
      bus.Checksum_Error <= 1'b0;
      bus.Timeout_Error  <= 1'b0;
      tcnt <= (strobe || state == HUNT) ? '0 : (tcnt == T_MAX) ? tcnt : tcnt + 1'b1;
      if (strobe) begin
        case (state)
          HUNT: if (bus.RX_Data == SYNC_BYTE) begin
            state   <= L_MSB;
            run_xor <= '0;
          end
          L_MSB: begin
            left_sh[15:8] <= bus.RX_Data;
            run_xor       <= run_xor ^ bus.RX_Data;
            state         <= L_LSB;
          end
          L_LSB: begin
            left_sh[7:0] <= bus.RX_Data;
            run_xor      <= run_xor ^ bus.RX_Data;
            state        <= R_MSB;
          end
          R_MSB: begin
            right_sh[15:8] <= bus.RX_Data;
            run_xor        <= run_xor ^ bus.RX_Data;
            state          <= R_LSB;
          end
          R_LSB: begin
            right_sh[7:0] <= bus.RX_Data;
            run_xor       <= run_xor ^ bus.RX_Data;
            state         <= CHECK;
          end
          CHECK: begin
            state <= HUNT;
            if (bus.RX_Data == run_xor) begin
              bus.Left_Sample  <= left_sh;
              bus.Right_Sample <= right_sh;
              bus.Frame_Count  <= bus.Frame_Count + 8'd1;
              bus.Sample_Valid <= 1'b1;
            end else begin
              bus.Checksum_Error <= 1'b1;
            end
          end
          default: state <= HUNT;
        endcase
      end else if (expire) begin
        state             <= HUNT;
        bus.Timeout_Error <= 1'b1;
      end
    end
  end
endmodule

// File: doc/rx_frame_controller.md
RX_FRAME_CONTROLLER -- requirements
Module: rx_frame_controller

Interface
REQ-001 The block SHALL expose parameter SYNC_BYTE, default 8'hA5, frame start marker.
REQ-002 The block SHALL expose parameter TIMEOUT_CYCLES, default 4096, maximum gap in clocks between bytes inside a frame.
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset: CLOCK_50  input  1  system clock; all logic on rising edge.
REQ-004 Reset_n  input  1  asynchronous active-low reset.
REQ-005 RX_Data  input  8  received byte from the UART receiver, stable while RX_Done is high.
REQ-006 RX_Done  input  1  receiver idle/finished flag; a 0->1 transition marks one newly received byte.
REQ-007 Left_Sample  output  16  last valid left-channel audio sample.
REQ-008 Right_Sample  output  16  last valid right-channel audio sample.
REQ-009 Sample_Valid  output  1  one-cycle pulse when Left_Sample and Right_Sample update.
REQ-010 Checksum_Error  output  1  one-cycle pulse when a frame is discarded for a bad checksum.
REQ-011 Timeout_Error  output  1  one-cycle pulse when a frame is abandoned for an inter-byte timeout.
REQ-012 Frame_Count  output  8  count of good frames; wraps from 255 to 0.

Function
REQ-013 Frame format SHALL be SYNC_BYTE, L[15:8], L[7:0], R[15:8], R[7:0], CHK, where CHK is the XOR of the four data bytes.
REQ-014 Byte strobe SHALL be RX_Done high in the current cycle and low in the registered previous sample; the previous-sample register resets to 1, so no strobe occurs on the first cycle after reset.
REQ-015 FSM states SHALL be HUNT, L_MSB, L_LSB, R_MSB, R_LSB, CHECK.
REQ-016 In HUNT, a strobe with RX_Data==SYNC_BYTE SHALL move to L_MSB; any other byte SHALL be ignored and the FSM stays in HUNT.
REQ-017 In L_MSB, L_LSB, R_MSB and R_LSB, each strobe SHALL capture RX_Data into a shadow register and advance one state; SYNC_BYTE values are treated as data.
REQ-018 A strobe in CHECK SHALL compare RX_Data to the running XOR; on match, shadows copy to Left_Sample/Right_Sample, Frame_Count increments and Sample_Valid pulses.
REQ-019 On mismatch in CHECK, Checksum_Error SHALL pulse, outputs and Frame_Count hold, and the FSM returns to HUNT.
REQ-020 CHECK SHALL always return to HUNT on its strobe.
REQ-021 Latency: for a strobe in cycle N, the state update and output registers SHALL change at the clock edge ending cycle N; pulses are high for exactly cycle N+1.
REQ-022 The timeout counter SHALL clear on every strobe and in HUNT, and increment each cycle otherwise.
REQ-023 When the timeout counter reaches TIMEOUT_CYCLES-1 outside HUNT, the FSM SHALL return to HUNT, Timeout_Error pulses and the partial frame is discarded.
REQ-024 If a strobe and timeout expiry coincide, the strobe SHALL win: the byte is processed and no timeout is flagged.
REQ-025 Sample_Valid, Checksum_Error and Timeout_Error SHALL be mutually exclusive in any cycle.
REQ-026 Counter width SHALL be ceil(log2(TIMEOUT_CYCLES)) bits and SHALL saturate, never wrapping.

Reset
REQ-027 While Reset_n=0, state SHALL be HUNT; Left_Sample, Right_Sample, shadows, XOR, timeout counter and Frame_Count are 0; all pulses are 0; the previous-RX_Done register is 1.
REQ-028 Reset asserted mid-frame SHALL discard the partial frame immediately with no error pulse.
REQ-029 The first strobe after Reset_n deasserts SHALL be evaluated in HUNT.

Verification
REQ-030 Bytes A5,12,34,56,78,08 -> Left_Sample=16'h1234, Right_Sample=16'h5678, one Sample_Valid pulse, Frame_Count=1.
REQ-031 Bytes A5,12,34,56,78,09 -> one Checksum_Error pulse, samples stay 0, Frame_Count=0, next A5 frame is accepted.
REQ-032 Bytes 00,FF,A5,A5,A5,A5,A5,00 -> leading bytes ignored, Left=16'hA5A5, Right=16'hA5A5, Sample_Valid pulse.
REQ-033 A5,12 then no strobe for 4096 cycles -> exactly one Timeout_Error pulse, back in HUNT; a strobe landing exactly on the expiry cycle produces no pulse.
REQ-034 Reset_n pulsed low after A5,12,34 -> outputs 0, no pulse; the following full frame decodes correctly.
REQ-035 256 good frames back-to-back -> Frame_Count wraps to 0 and exactly 256 Sample_Valid pulses occur.
